// File: rtl/instr_encoder.sv
// instr_encoder: packs a mnemonic plus register/immediate fields into a 32-bit MIPS-style word
// and streams the words into instruction memory at consecutive word addresses.
// Latency: write strobe two cycles after the accept cycle; one instruction per 3 cycles.
// Backpressure: in_ready only in IDLE with finish/clear low; FULL and DONE hold in_ready low.
// Optional feature: define INSTR_ENCODER_NOP_PAD_EN to fill the rest of memory with NOPs on finish.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   instruction-field handshake
//   op_sel                mnemonic (0 ADD .. 6 SLT, 7 LW, 8 SW, 9 BEQ, 10 J, 11 ADDI .. 15 SLTI)
//   rs, rt, rd            register fields
//   imm, target           I-type immediate, J-type target
//   finish, clear         end-of-program request, synchronous restart to address 0
//   imem_we/addr/wdata    instruction-memory write port
//   count                 words written so far (reaches 2^ADDR_W when memory is full)
//   full, done            status flags
module instr_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    input  logic              finish,
    input  logic              clear,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        ENCODE,
        WRITE,
`ifdef INSTR_ENCODER_NOP_PAD_EN
        PAD,
`endif
        FULL,
        DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]  op_q;
    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic [4:0]  rd_q;
    logic [15:0] imm_q;
    logic [25:0] target_q;

    logic wr;
    logic last;
    logic accept;

    // Word assembly; fields that a format does not use are simply not placed.
    function automatic logic [31:0] encode(
        input logic [3:0]  op,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [15:0] f_imm,
        input logic [25:0] f_target
    );
        logic [31:0] word;
        word = 32'h0;
        case (op)
            4'd0:    word = {6'h00, f_rs, f_rt, f_rd, 5'h00, 6'h20};
            4'd1:    word = {6'h00, f_rs, f_rt, f_rd, 5'h00, 6'h22};
            4'd2:    word = {6'h00, f_rs, f_rt, f_rd, 5'h00, 6'h24};
            4'd3:    word = {6'h00, f_rs, f_rt, f_rd, 5'h00, 6'h25};
            4'd4:    word = {6'h00, f_rs, f_rt, f_rd, 5'h00, 6'h26};
            4'd5:    word = {6'h00, f_rs, f_rt, f_rd, 5'h00, 6'h27};
            4'd6:    word = {6'h00, f_rs, f_rt, f_rd, 5'h00, 6'h2A};
            4'd7:    word = {6'h23, f_rs, f_rt, f_imm};
            4'd8:    word = {6'h2B, f_rs, f_rt, f_imm};
            4'd9:    word = {6'h04, f_rs, f_rt, f_imm};
            4'd10:   word = {6'h02, f_target};
            4'd11:   word = {6'h08, f_rs, f_rt, f_imm};
            4'd12:   word = {6'h0C, f_rs, f_rt, f_imm};
            4'd13:   word = {6'h0D, f_rs, f_rt, f_imm};
            4'd14:   word = {6'h0E, f_rs, f_rt, f_imm};
            default: word = {6'h0A, f_rs, f_rt, f_imm};
        endcase
        return word;
    endfunction

    // finish and clear both block acceptance so the fields of a finishing cycle are dropped.
    assign in_ready = (state == IDLE) & ~finish & ~clear;
    assign accept   = in_valid & in_ready;
    assign last     = (imem_addr == {ADDR_W{1'b1}});

    // clear aborts an in-flight write in the same cycle, so the strobe is gated combinationally.
    assign imem_we  = wr & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr        = 1'b0;
        case (state)
            IDLE: begin
                if (finish) begin
`ifdef INSTR_ENCODER_NOP_PAD_EN
                    state_nxt = PAD;
`else
                    state_nxt = DONE;
`endif
                end else if (in_valid) begin
                    state_nxt = ENCODE;
                end
            end
            ENCODE: state_nxt = WRITE;
            WRITE: begin
                wr        = 1'b1;
                state_nxt = last ? FULL : IDLE;
            end
`ifdef INSTR_ENCODER_NOP_PAD_EN
            PAD: begin
                wr = 1'b1;
                if (last) begin
                    state_nxt = DONE;
                end
            end
`endif
            FULL: begin
                if (finish) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (clear) begin
            state_nxt = IDLE;
            wr        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            target_q   <= '0;
            imem_wdata <= '0;
            imem_addr  <= '0;
            count      <= '0;
            full       <= 1'b0;
            done       <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= op_sel;
                rs_q     <= rs;
                rt_q     <= rt;
                rd_q     <= rd;
                imm_q    <= imm;
                target_q <= target;
            end
            if (state == ENCODE) begin
                imem_wdata <= encode(op_q, rs_q, rt_q, rd_q, imm_q, target_q);
            end
`ifdef INSTR_ENCODER_NOP_PAD_EN
            // Padding reuses the write path with an all-zero (NOP) word.
            if (state_nxt == PAD) begin
                imem_wdata <= '0;
            end
`endif
            if (clear) begin
                imem_addr <= '0;
                count     <= '0;
                full      <= 1'b0;
            end else if (wr) begin
                // Address rolls to 0 on the last slot, but FULL/DONE stop further writes.
                imem_addr <= imem_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                count     <= count + {{ADDR_W{1'b0}}, 1'b1};
                if (last) begin
                    full <= 1'b1;
                end
            end
            done <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op_sel;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              finish;
    logic              clear;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int          obs_addr[$];
    logic [31:0] obs_data[$];
    int          obs_cyc[$];
    logic [31:0] exp_q[$];

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic [25:0] tgt;
    } instr_t;

    // Reference tables from the instruction-set definition.
    logic [31:0] r_funct [16] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h26, 32'h27, 32'h2A,
                                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] i_opc   [16] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                  32'h23, 32'h2B, 32'h04, 32'h02, 32'h08, 32'h0C, 32'h0D, 32'h0E, 32'h0A};

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_sel     (op_sel),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .imm        (imm),
        .target     (target),
        .finish     (finish),
        .clear      (clear),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port monitor, sampled mid-cycle.
    always @(posedge clk) begin
        #2;
        if (imem_we === 1'b1) begin
            obs_addr.push_back(int'(imem_addr));
            obs_data.push_back(imem_wdata);
            obs_cyc.push_back(cyc);
        end
    end

    function automatic logic [31:0] ref_word(input instr_t i);
        logic [31:0] w;
        if (i.op <= 4'd6)
            w = (32'(i.rs) << 21) | (32'(i.rt) << 16) | (32'(i.rd) << 11) | r_funct[i.op];
        else if (i.op == 4'd10)
            w = (i_opc[i.op] << 26) | 32'(i.tgt);
        else
            w = (i_opc[i.op] << 26) | (32'(i.rs) << 21) | (32'(i.rt) << 16) | 32'(i.imm);
        return w;
    endfunction

    function automatic instr_t rand_instr(input logic [3:0] op);
        instr_t i;
        i.op  = op;
        i.rs  = 5'($urandom);
        i.rt  = 5'($urandom);
        i.rd  = 5'($urandom);
        i.imm = 16'($urandom);
        i.tgt = 26'($urandom);
        return i;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fields(input instr_t i);
        op_sel = i.op;
        rs     = i.rs;
        rt     = i.rt;
        rd     = i.rd;
        imm    = i.imm;
        target = i.tgt;
    endtask

    // Called at edge+1; returns at edge+1 of the cycle after the accept edge.
    task automatic send(input instr_t i, output int acc_cyc);
        bit ok;
        ok      = 1'b0;
        acc_cyc = -1;
        drive_fields(i);
        in_valid = 1'b1;
        for (int w = 0; w < 20 && !ok; w++) begin
            #1;
            if (in_ready === 1'b1) begin
                ok      = 1'b1;
                acc_cyc = cyc;
            end
            cycle();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL send_accept: in_ready stayed %b, wanted 1 within 20 cycles", in_ready);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        finish   = 1'b0;
        clear    = 1'b0;
        cycle();
        rst = 1'b0;
        obs_addr.delete();
        obs_data.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        drive_fields(rand_instr(4'($urandom)));
        in_valid = 1'b1;
        finish   = 1'b0;
        clear    = 1'b0;
        rst      = 1'b1;
        cycle();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_cmp++; if (imem_we !== 1'b0)   begin n_bad++; $display("FAIL reset_we: got %b want 0", imem_we); end
        n_cmp++; if (imem_addr !== '0)   begin n_bad++; $display("FAIL reset_addr: got %0d want 0", imem_addr); end
        n_cmp++; if (imem_wdata !== '0)  begin n_bad++; $display("FAIL reset_wdata: got %h want 0", imem_wdata); end
        n_cmp++; if (count !== '0)       begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
        n_cmp++; if (full !== 1'b0)      begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (done !== 1'b0)      begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        cycle();
    endtask

    task automatic test_add();
        instr_t i;
        int acc;
        do_reset();
        i = rand_instr(4'd0);
        i.rd = 5'd3; i.rs = 5'd1; i.rt = 5'd2;
        send(i, acc);
        cycle();
        #1;
        n_cmp++; if (imem_we !== 1'b1)          begin n_bad++; $display("FAIL add_we: got %b want 1", imem_we); end
        n_cmp++; if (imem_addr !== '0)          begin n_bad++; $display("FAIL add_addr: got %0d want 0", imem_addr); end
        n_cmp++; if (imem_wdata !== 32'h00221820) begin n_bad++; $display("FAIL add_wdata: got %h want 00221820", imem_wdata); end
        n_cmp++; if (cyc != acc + 2)            begin n_bad++; $display("FAIL add_latency: strobe cycle %0d want %0d", cyc, acc + 2); end
        cycle();
        #1;
        n_cmp++; if (count !== 7'd1)            begin n_bad++; $display("FAIL add_count: got %0d want 1", count); end
        n_cmp++; if (imem_addr !== 6'd1)        begin n_bad++; $display("FAIL add_addr_inc: got %0d want 1", imem_addr); end
        cycle();
    endtask

    task automatic test_lw_j();
        instr_t i;
        int acc;
        do_reset();
        i = rand_instr(4'd7);
        i.rt = 5'd8; i.rs = 5'd29; i.imm = 16'h0004;
        send(i, acc);
        i = rand_instr(4'd10);
        i.tgt = 26'h0000010;
        send(i, acc);
        repeat (3) cycle();
        n_cmp++; if (obs_data.size() != 2) begin n_bad++; $display("FAIL lwj_writes: got %0d want 2", obs_data.size()); end
        if (obs_data.size() >= 2) begin
            n_cmp++; if (obs_data[0] !== 32'h8FA80004) begin n_bad++; $display("FAIL lwj_lw_word: got %h want 8FA80004", obs_data[0]); end
            n_cmp++; if (obs_addr[0] != 0)             begin n_bad++; $display("FAIL lwj_lw_addr: got %0d want 0", obs_addr[0]); end
            n_cmp++; if (obs_data[1] !== 32'h08000010) begin n_bad++; $display("FAIL lwj_j_word: got %h want 08000010", obs_data[1]); end
            n_cmp++; if (obs_addr[1] != 1)             begin n_bad++; $display("FAIL lwj_j_addr: got %0d want 1", obs_addr[1]); end
            n_cmp++; if (obs_cyc[1] - obs_cyc[0] != 3) begin n_bad++; $display("FAIL lwj_spacing: got %0d want 3", obs_cyc[1] - obs_cyc[0]); end
        end
    endtask

    task automatic test_random();
        instr_t i;
        int acc;
        int n;
        do_reset();
        n = 24;
        for (int k = 0; k < n; k++) begin
            i = rand_instr(4'($urandom));
            exp_q.push_back(ref_word(i));
            send(i, acc);
        end
        repeat (3) cycle();
        n_cmp++; if (obs_data.size() != n) begin n_bad++; $display("FAIL rand_writes: got %0d want %0d", obs_data.size(), n); end
        for (int k = 0; k < n && k < obs_data.size(); k++) begin
            n_cmp++; if (obs_data[k] !== exp_q[k]) begin n_bad++; $display("FAIL rand_word[%0d]: got %h want %h", k, obs_data[k], exp_q[k]); end
            n_cmp++; if (obs_addr[k] != k)         begin n_bad++; $display("FAIL rand_addr[%0d]: got %0d want %0d", k, obs_addr[k], k); end
            if (k > 0) begin
                n_cmp++; if (obs_cyc[k] - obs_cyc[k-1] != 3) begin n_bad++; $display("FAIL rand_spacing[%0d]: got %0d want 3", k, obs_cyc[k] - obs_cyc[k-1]); end
            end
        end
        #1;
        n_cmp++; if (count !== 7'(n)) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", count, n); end
        cycle();
    endtask

    task automatic test_full();
        instr_t i;
        int acc;
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            i = rand_instr(4'd11);
            exp_q.push_back(ref_word(i));
            send(i, acc);
        end
        cycle();
        cycle();
        drive_fields(rand_instr(4'd11));
        in_valid = 1'b1;
        #1;
        n_cmp++; if (full !== 1'b1)       begin n_bad++; $display("FAIL full_flag: got %b want 1", full); end
        n_cmp++; if (count !== 7'(DEPTH)) begin n_bad++; $display("FAIL full_count: got %0d want %0d", count, DEPTH); end
        n_cmp++; if (imem_addr !== '0)    begin n_bad++; $display("FAIL full_addr: got %0d want 0", imem_addr); end
        n_cmp++; if (in_ready !== 1'b0)   begin n_bad++; $display("FAIL full_ready: got %b want 0", in_ready); end
        for (int k = 0; k < 5; k++) begin
            cycle();
            #1;
            n_cmp++; if (imem_we !== 1'b0 || in_ready !== 1'b0) begin n_bad++; $display("FAIL full_ignore[%0d]: we=%b ready=%b want 0/0", k, imem_we, in_ready); end
        end
        in_valid = 1'b0;
        n_cmp++; if (obs_data.size() != DEPTH) begin n_bad++; $display("FAIL full_writes: got %0d want %0d", obs_data.size(), DEPTH); end
        for (int k = 0; k < DEPTH && k < obs_data.size(); k++) begin
            n_cmp++; if (obs_data[k] !== exp_q[k] || obs_addr[k] != k) begin n_bad++; $display("FAIL full_entry[%0d]: got %h@%0d want %h@%0d", k, obs_data[k], obs_addr[k], exp_q[k], k); end
        end
        cycle();
        finish = 1'b1;
        cycle();
        finish = 1'b0;
        #1;
        n_cmp++; if (done !== 1'b1)     begin n_bad++; $display("FAIL full_done: got %b want 1", done); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL full_done_ready: got %b want 0", in_ready); end
        cycle();
    endtask

    task automatic test_finish();
        instr_t i;
        int acc;
        int fin_cyc;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            i = rand_instr(4'($urandom));
            exp_q.push_back(ref_word(i));
            send(i, acc);
        end
        cycle();
        cycle();
        drive_fields(rand_instr(4'($urandom)));
        in_valid = 1'b1;
        finish   = 1'b1;
        #1;
        fin_cyc = cyc;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fin_ready: got %b want 0", in_ready); end
        cycle();
        in_valid = 1'b0;
        finish   = 1'b0;
`ifdef INSTR_ENCODER_NOP_PAD_EN
        for (int w = 0; w < 80 && done !== 1'b1; w++) cycle();
        #1;
        n_cmp++; if (done !== 1'b1)       begin n_bad++; $display("FAIL pad_done: got %b want 1", done); end
        n_cmp++; if (count !== 7'(DEPTH)) begin n_bad++; $display("FAIL pad_count: got %0d want %0d", count, DEPTH); end
        n_cmp++; if (full !== 1'b1)       begin n_bad++; $display("FAIL pad_full: got %b want 1", full); end
        n_cmp++; if (obs_data.size() != DEPTH) begin n_bad++; $display("FAIL pad_writes: got %0d want %0d", obs_data.size(), DEPTH); end
        for (int k = 0; k < DEPTH && k < obs_data.size(); k++) begin
            if (k < 3) begin
                n_cmp++; if (obs_data[k] !== exp_q[k]) begin n_bad++; $display("FAIL pad_prog[%0d]: got %h want %h", k, obs_data[k], exp_q[k]); end
            end else begin
                n_cmp++;
                if (obs_data[k] !== 32'h0 || obs_addr[k] != k || obs_cyc[k] != fin_cyc + 1 + (k - 3)) begin
                    n_bad++;
                    $display("FAIL pad_nop[%0d]: got %h@%0d cyc %0d want 0@%0d cyc %0d", k, obs_data[k], obs_addr[k], obs_cyc[k], k, fin_cyc + 1 + (k - 3));
                end
            end
        end
`else
        #1;
        n_cmp++; if (done !== 1'b1)   begin n_bad++; $display("FAIL fin_done: got %b want 1", done); end
        n_cmp++; if (count !== 7'd3)  begin n_bad++; $display("FAIL fin_count: got %0d want 3", count); end
        repeat (4) cycle();
        #1;
        n_cmp++; if (obs_data.size() != 3) begin n_bad++; $display("FAIL fin_writes: got %0d want 3", obs_data.size()); end
        n_cmp++; if (done !== 1'b1 || in_ready !== 1'b0) begin n_bad++; $display("FAIL fin_hold: done=%b ready=%b want 1/0", done, in_ready); end
        for (int k = 0; k < 3 && k < obs_data.size(); k++) begin
            n_cmp++; if (obs_data[k] !== exp_q[k]) begin n_bad++; $display("FAIL fin_prog[%0d]: got %h want %h", k, obs_data[k], exp_q[k]); end
        end
`endif
        cycle();
    endtask

    task automatic test_clear();
        instr_t i;
        int acc;
        do_reset();
        send(rand_instr(4'd0), acc);
        cycle();
        cycle();
        send(rand_instr(4'd1), acc);
        cycle();
        clear = 1'b1;
        #1;
        n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL clr_we: got %b want 0", imem_we); end
        cycle();
        clear = 1'b0;
        #1;
        n_cmp++; if (imem_addr !== '0)  begin n_bad++; $display("FAIL clr_addr: got %0d want 0", imem_addr); end
        n_cmp++; if (count !== '0)      begin n_bad++; $display("FAIL clr_count: got %0d want 0", count); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL clr_ready: got %b want 1", in_ready); end
        n_cmp++; if (obs_data.size() != 1) begin n_bad++; $display("FAIL clr_writes: got %0d want 1", obs_data.size()); end
        cycle();
        i = rand_instr(4'($urandom));
        send(i, acc);
        repeat (2) cycle();
        n_cmp++;
        if (obs_data.size() != 2 || obs_addr[obs_addr.size()-1] != 0 || obs_data[obs_data.size()-1] !== ref_word(i)) begin
            n_bad++;
            $display("FAIL clr_restart: %0d writes, last %h@%0d, want 2 writes, %h@0",
                     obs_data.size(), obs_data[obs_data.size()-1], obs_addr[obs_addr.size()-1], ref_word(i));
        end
        finish = 1'b1;
        cycle();
        finish = 1'b0;
        for (int w = 0; w < 80 && done !== 1'b1; w++) cycle();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        #1;
        n_cmp++; if (done !== 1'b0 || full !== 1'b0) begin n_bad++; $display("FAIL clr_done: done=%b full=%b want 0/0", done, full); end
        n_cmp++; if (count !== '0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL clr_done_state: count=%0d ready=%b want 0/1", count, in_ready); end
        cycle();
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        finish   = 1'b0;
        clear    = 1'b0;
        op_sel   = '0;
        rs       = '0;
        rt       = '0;
        rd       = '0;
        imm      = '0;
        target   = '0;
        test_reset();
        test_add();
        test_lw_j();
        test_random();
        test_full();
        test_finish();
        test_clear();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
